kmap_sweep_checker: RTL and testbench

Self-checking stimulus stage that sits directly upstream of a 4-input K-map combinational block (inputs x1..x4, output f). On `start` it drives all 16 input combinations in turn and holds each for a programmable number of cycles. It samples the block's `f` at the end of each hold window and compares it with a 16-bit expected truth table. It reports a per-minterm mismatch mask, an error count and a pass/done indication, replacing hand-written exhaustive benches with a reusable synthesizable sequencer.

---
 rtl/kmap_sweep_pkg.sv | 14 +
 rtl/kmap_sweep_if.sv | 28 ++
 rtl/kmap_hold_timer.sv | 29 ++
 rtl/kmap_sweep_checker.sv | 143 ++++++++++++++
 tb/tb_kmap_sweep_checker.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/kmap_sweep_pkg.sv
// Shared state encoding and sizing for the K-map sweep checker.
package kmap_sweep_pkg;

    localparam int NUM_MINTERMS = 16;
    localparam int STEP_W       = 4;
    localparam int CNT_W        = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/kmap_sweep_if.sv
// Control, result and stimulus signals between the sweep checker and its environment.
interface kmap_sweep_if;
    import kmap_sweep_pkg::*;

    logic                    start;
    logic [NUM_MINTERMS-1:0] expected;
    logic                    f;
    logic                    x1;
    logic                    x2;
    logic                    x3;
    logic                    x4;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [NUM_MINTERMS-1:0] mismatch;
    logic [CNT_W-1:0]        count_err;

    modport master (
        output start, expected, f,
        input  x1, x2, x3, x4, busy, done, pass, mismatch, count_err
    );

    modport slave (
        input  start, expected, f,
        output x1, x2, x3, x4, busy, done, pass, mismatch, count_err
    );

endinterface

// File: rtl/kmap_hold_timer.sv
// Hold-window timer: a down-counter reloaded to HOLD_CYCLES-1; 'last' flags the final cycle of each window.
module kmap_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

    logic [7:0] cnt;

    // Wraps back to RELOAD on its own so consecutive windows need no extra load pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || (en && cnt == 8'd0)) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign last = (cnt == 8'd0);

endmodule

// File: rtl/kmap_sweep_checker.sv
// Exhaustive 4-input sweep sequencer that compares a K-map block's f against a latched truth table.
// Define KMAP_SWEEP_GRAY_EN to visit minterms in Gray order instead of binary order.
module kmap_sweep_checker
    import kmap_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input logic         clk,
    input logic         rst_n,
    kmap_sweep_if.slave bus
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_MINTERMS - 1);

    function automatic logic [STEP_W-1:0] order(input logic [STEP_W-1:0] s);
`ifdef KMAP_SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    state_t                  state_q, state_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [NUM_MINTERMS-1:0] exp_q, exp_d;
    logic [STEP_W-1:0]       x_q, x_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [NUM_MINTERMS-1:0] mismatch_q, mismatch_d;
    logic [CNT_W-1:0]        count_err_q, count_err_d;
    logic                    timer_load, timer_en, timer_last;
    logic [STEP_W-1:0]       sample_idx;

    kmap_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .en   (timer_en),
        .last (timer_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            exp_q       <= '0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            mismatch_q  <= '0;
            count_err_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            exp_q       <= exp_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            mismatch_q  <= mismatch_d;
            count_err_q <= count_err_d;
        end
    end

    // Every output is computed one cycle ahead so that all of them leave the block registered.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        exp_d       = exp_q;
        x_d         = x_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        mismatch_d  = mismatch_q;
        count_err_d = count_err_q;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        sample_idx  = order(step_q);

        case (state_q)
            IDLE: begin
                x_d    = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    timer_load  = 1'b1;
                    exp_d       = bus.expected;
                    mismatch_d  = '0;
                    count_err_d = '0;
                    pass_d      = 1'b0;
                    step_d      = '0;
                    x_d         = order('0);
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                timer_en = 1'b1;
                busy_d   = 1'b1;
                if (timer_last) begin
                    if (bus.f != exp_q[sample_idx]) begin
                        mismatch_d[sample_idx] = 1'b1;
                        count_err_d            = count_err_q + CNT_W'(1);
                    end
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        x_d     = '0;
                        done_d  = 1'b1;
                        pass_d  = (count_err_d == '0);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                        x_d    = order(step_q + STEP_W'(1));
                    end
                end
            end
            DONE: begin
                x_d     = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.x1        = x_q[3];
    assign bus.x2        = x_q[2];
    assign bus.x3        = x_q[1];
    assign bus.x4        = x_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.count_err = count_err_q;

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Directed bench for kmap_sweep_checker: table of full sweeps plus reset, ignored-start and back-to-back sequences.
module tb_kmap_sweep_checker;

    localparam int H      = 4;
    localparam int SWEEP  = 16 * H;
    localparam int LIMIT  = 400;

    typedef struct {
        string       name;
        logic [15:0] exp_tt;
        int          mode;
        logic        want_pass;
        logic [15:0] want_mm;
        logic [4:0]  want_cnt;
    } vec_t;

`ifdef KMAP_SWEEP_GRAY_EN
    int order_tbl [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
`else
    int order_tbl [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

    logic clk;
    logic rst_n;
    int   f_mode;
    int   n_cmp;
    int   n_fail;
    vec_t vecs [8];

    kmap_sweep_if bus ();

    kmap_sweep_checker #(
        .HOLD_CYCLES(H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block under test: 0 parity, 1 stuck-0, 2 f=x1, 3 stuck-1, other f=x4.
    always_comb begin
        case (f_mode)
            0:       bus.f = bus.x1 ^ bus.x2 ^ bus.x3 ^ bus.x4;
            1:       bus.f = 1'b0;
            2:       bus.f = bus.x1;
            3:       bus.f = 1'b1;
            default: bus.f = bus.x4;
        endcase
    end

    function automatic logic [3:0] get_x();
        return {bus.x1, bus.x2, bus.x3, bus.x4};
    endfunction

    function automatic logic [27:0] all_outs();
        return {bus.x1, bus.x2, bus.x3, bus.x4, bus.busy, bus.done, bus.pass, bus.mismatch, bus.count_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Accepts a sweep, scrambles 'expected' afterwards, optionally pulses start at cycle pulse_at,
    // and returns edges from acceptance to done plus the number of wrong x/busy observations.
    task automatic run_sweep(input logic [15:0] exp_tt, input int mode, input int pulse_at,
                             output int latency, output int x_errs);
        f_mode       = mode;
        bus.expected = exp_tt;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.expected = ~exp_tt;
        latency      = 0;
        x_errs       = 0;
        while (!bus.done && latency < LIMIT) begin
            if (latency < SWEEP) begin
                if (get_x() !== 4'(order_tbl[latency / H]) || bus.busy !== 1'b1) x_errs++;
            end
            bus.start = (latency == pulse_at);
            tick();
            latency++;
        end
        bus.start = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        int lat;
        int xe;
        run_sweep(v.exp_tt, v.mode, -1, lat, xe);
        check_output({v.name, " latency"}, lat, SWEEP);
        check_output({v.name, " x_seq"}, xe, 0);
        check_output({v.name, " pass"}, bus.pass, v.want_pass);
        check_output({v.name, " mismatch"}, bus.mismatch, v.want_mm);
        check_output({v.name, " count_err"}, bus.count_err, v.want_cnt);
        check_output({v.name, " idle_x_busy"}, {get_x(), bus.busy}, 5'b0);
        tick();
        check_output({v.name, " done_pulse"}, bus.done, 1'b0);
        check_output({v.name, " pass_hold"}, bus.pass, v.want_pass);
    endtask

    initial begin
        int lat;
        int xe;
        int t;
        int dones;

        n_cmp        = 0;
        n_fail       = 0;
        f_mode       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.expected = 16'h0;

        vecs[0] = '{"parity_pass",   16'h6996, 0, 1'b1, 16'h0000, 5'd0};
        vecs[1] = '{"stuck0_fail",   16'h6996, 1, 1'b0, 16'h6996, 5'd8};
        vecs[2] = '{"x1_pass",       16'hFF00, 2, 1'b1, 16'h0000, 5'd0};
        vecs[3] = '{"x1_one_fail",   16'hFF01, 2, 1'b0, 16'h0001, 5'd1};
        vecs[4] = '{"stuck1_fail",   16'h6996, 3, 1'b0, 16'h9669, 5'd8};
        vecs[5] = '{"parity_vs_0",   16'h0000, 0, 1'b0, 16'h6996, 5'd8};
        vecs[6] = '{"stuck1_pass",   16'hFFFF, 3, 1'b1, 16'h0000, 5'd0};
        vecs[7] = '{"x4_all_fail",   16'h5555, 4, 1'b0, 16'hFFFF, 5'd16};

        tick();
        tick();
        check_output("reset_outputs", all_outs(), 28'h0);
        rst_n = 1'b1;
        tick();
        check_output("idle_outputs", all_outs(), 28'h0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // A start pulse mid-sweep must not disturb the running sweep or queue another.
        run_sweep(16'h6996, 0, 10, lat, xe);
        check_output("ign_start latency", lat, SWEEP);
        check_output("ign_start x_seq", xe, 0);
        check_output("ign_start pass", bus.pass, 1'b1);
        dones = 0;
        for (int i = 0; i < 2 * SWEEP; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        check_output("ign_start no_rerun", dones, 0);

        // Reset mid-sweep clears everything and suppresses done.
        f_mode       = 1;
        bus.expected = 16'h6996;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check_output("pre_reset busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check_output("mid_reset outputs", all_outs(), 28'h0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 2 * SWEEP; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        check_output("mid_reset no_done", dones, 0);
        apply_stimulus(vecs[0]);

        // Start held high: the next sweep is accepted in the first IDLE cycle.
        f_mode       = 0;
        bus.expected = 16'h6996;
        bus.start    = 1'b1;
        tick();
        t = 0;
        while (bus.busy && t < LIMIT) begin
            tick();
            t++;
        end
        check_output("b2b done_at", {bus.done, 8'(t)}, {1'b1, 8'(SWEEP)});
        while (!bus.busy && t < LIMIT) begin
            tick();
            t++;
        end
        check_output("b2b period", t, SWEEP + 2);
        bus.start = 1'b0;
        t = 0;
        while (!bus.done && t < LIMIT) begin
            tick();
            t++;
        end
        check_output("b2b second_pass", {bus.done, bus.pass, bus.count_err}, {1'b1, 1'b1, 5'd0});
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
